// File: rtl/trap_ctrl_if.sv
// Bundle between EX / CSR file / PC control and the trap controller.
// The controller uses the slave view; the core side drives the master view.
interface trap_ctrl_if #(parameter int XLEN = 32);
  logic            time_up_i;
  logic            msip_i;
  logic            inst_valid_i;
  logic [XLEN-1:0] inst_addr_i;
  logic            ecall_i;
  logic            ebreak_i;
  logic            mret_i;
  logic [XLEN-1:0] csr_mstatus_i;
  logic [XLEN-1:0] csr_mie_i;
  logic [XLEN-1:0] csr_mtvec_i;
  logic [XLEN-1:0] csr_mepc_i;
  logic            hold_flag_o;
  logic            csr_we_o;
  logic [11:0]     csr_waddr_o;
  logic [XLEN-1:0] csr_wdata_o;
  logic            int_assert_o;
  logic [XLEN-1:0] int_addr_o;

  modport master (
    output time_up_i, msip_i, inst_valid_i, inst_addr_i, ecall_i, ebreak_i, mret_i,
           csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
    input  hold_flag_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o
  );

  modport slave (
    input  time_up_i, msip_i, inst_valid_i, inst_addr_i, ecall_i, ebreak_i, mret_i,
           csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i,
    output hold_flag_o, csr_we_o, csr_waddr_o, csr_wdata_o, int_assert_o, int_addr_o
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap/return sequencer: stalls the pipe, writes mepc/mstatus/mcause
// one per cycle through the CSR port, then redirects fetch.
module trap_ctrl #(
  parameter bit VECTORED = 1'b0,
  parameter int XLEN     = 32
) (
  input logic         clk,
  input logic         rst,
  trap_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {
    IDLE, SAVE_MEPC, SAVE_MSTATUS, SAVE_MCAUSE, TRAP_JUMP, MRET_MSTATUS, MRET_JUMP
  } state_t;

  localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_MSI    = {1'b1, (XLEN-1)'(3)};
  localparam logic [XLEN-1:0] CAUSE_MTI    = {1'b1, (XLEN-1)'(7)};

  state_t          state, state_n;
  logic [XLEN-1:0] epc, cause, target;
  logic [XLEN-1:0] cause_n, target_n, ms_trap, ms_mret;
  logic            trap_req, mret_req, sw_int, tm_int;

  // Request detection and priority; only meaningful in IDLE on a real instruction.
  always_comb begin
    trap_req = 1'b0;
    mret_req = 1'b0;
    cause_n  = '0;
    sw_int   = bus.msip_i    & bus.csr_mstatus_i[3] & bus.csr_mie_i[3];
    tm_int   = bus.time_up_i & bus.csr_mstatus_i[3] & bus.csr_mie_i[7];
    if (state == IDLE && bus.inst_valid_i) begin
      if (bus.ecall_i) begin
        trap_req = 1'b1;
        cause_n  = CAUSE_ECALL;
      end else if (bus.ebreak_i) begin
        trap_req = 1'b1;
        cause_n  = CAUSE_EBREAK;
      end else if (bus.mret_i) begin
        mret_req = 1'b1;
      end else if (sw_int) begin
        trap_req = 1'b1;
        cause_n  = CAUSE_MSI;
      end else if (tm_int) begin
        trap_req = 1'b1;
        cause_n  = CAUSE_MTI;
      end
    end
    target_n = {bus.csr_mtvec_i[XLEN-1:2], 2'b00};
    if (VECTORED && cause_n[XLEN-1])
      target_n = target_n + {cause_n[XLEN-3:0], 2'b00};
  end

  always_comb begin
    ms_trap    = bus.csr_mstatus_i;
    ms_trap[7] = bus.csr_mstatus_i[3];
    ms_trap[3] = 1'b0;
    ms_mret    = bus.csr_mstatus_i;
    ms_mret[3] = bus.csr_mstatus_i[7];
    ms_mret[7] = 1'b1;
  end

  always_comb begin
    state_n          = state;
    bus.hold_flag_o  = 1'b0;
    bus.csr_we_o     = 1'b0;
    bus.csr_waddr_o  = '0;
    bus.csr_wdata_o  = '0;
    bus.int_assert_o = 1'b0;
    bus.int_addr_o   = '0;
    case (state)
      IDLE: begin
        bus.hold_flag_o = trap_req | mret_req;
        if (trap_req)      state_n = SAVE_MEPC;
        else if (mret_req) state_n = MRET_MSTATUS;
      end
      SAVE_MEPC: begin
        bus.hold_flag_o = 1'b1;
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = 12'h341;
        bus.csr_wdata_o = epc;
        state_n         = SAVE_MSTATUS;
      end
      SAVE_MSTATUS: begin
        bus.hold_flag_o = 1'b1;
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = 12'h300;
        bus.csr_wdata_o = ms_trap;
        state_n         = SAVE_MCAUSE;
      end
      SAVE_MCAUSE: begin
        bus.hold_flag_o = 1'b1;
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = 12'h342;
        bus.csr_wdata_o = cause;
        state_n         = TRAP_JUMP;
      end
      TRAP_JUMP: begin
        bus.hold_flag_o  = 1'b1;
        bus.int_assert_o = 1'b1;
        bus.int_addr_o   = target;
        state_n          = IDLE;
      end
      MRET_MSTATUS: begin
        bus.hold_flag_o = 1'b1;
        bus.csr_we_o    = 1'b1;
        bus.csr_waddr_o = 12'h300;
        bus.csr_wdata_o = ms_mret;
        state_n         = MRET_JUMP;
      end
      MRET_JUMP: begin
        bus.hold_flag_o  = 1'b1;
        bus.int_assert_o = 1'b1;
        bus.int_addr_o   = bus.csr_mepc_i;
        state_n          = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Outputs are forced quiet during reset even if the old state was mid-sequence.
    if (rst) begin
      state_n          = IDLE;
      bus.hold_flag_o  = 1'b0;
      bus.csr_we_o     = 1'b0;
      bus.csr_waddr_o  = '0;
      bus.csr_wdata_o  = '0;
      bus.int_assert_o = 1'b0;
      bus.int_addr_o   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      epc    <= '0;
      cause  <= '0;
      target <= '0;
    end else begin
      state <= state_n;
      if (trap_req) begin
        epc    <= bus.inst_addr_i;
        cause  <= cause_n;
        target <= target_n;
      end
    end
  end
endmodule
